// File: rtl/sram_bus_arbiter.sv
// Two-port arbiter for a multiplexed, address-latched 8-bit SRAM bus.
// Each grant runs one complete read or write cycle; writes to PROTECT_ADDR become io_wr_stb.
module sram_bus_arbiter #(
    parameter int          WAIT_CYCLES  = 0,
    parameter int          PRIO_MODE    = 0,
    parameter logic [7:0]  PROTECT_ADDR = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       mem_le,
    output logic       mem_oe_n,
    output logic       mem_we_n,
    output logic [7:0] bus_out,
    output logic [7:0] bus_oe,
    input  logic [7:0] bus_in,
    output logic       io_wr_stb,
    output logic [7:0] io_wdata,
    output logic       busy,
    output logic       grant_host
);

    typedef enum logic [2:0] {
        IDLE, ADDR, LATCH, TURN, SAMPLE, DATA, STROBE, DONE
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_t     state_reg;
    logic [2:0] wait_reg;
    logic [7:0] addr_reg;
    logic [7:0] wdata_reg;
    logic       we_reg;
    logic       last_host_reg;

    logic       pick_host;
    logic       protected_wr;
    logic [7:0] sel_addr;

    // Host wins unless only cpu asks, or on a round-robin tie where host went last.
    assign pick_host    = host_req && (!cpu_req || (PRIO_MODE != 0) || !last_host_reg);
    assign sel_addr     = pick_host ? host_addr : cpu_addr;
    assign protected_wr = we_reg && (addr_reg == PROTECT_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wait_reg      <= 3'd0;
            addr_reg      <= 8'h00;
            wdata_reg     <= 8'h00;
            we_reg        <= 1'b0;
            last_host_reg <= 1'b0;
            mem_le        <= 1'b1;
            mem_oe_n      <= 1'b1;
            mem_we_n      <= 1'b1;
            bus_out       <= 8'h00;
            bus_oe        <= 8'h00;
            cpu_ack       <= 1'b0;
            host_ack      <= 1'b0;
            cpu_rdata     <= 8'h00;
            host_rdata    <= 8'h00;
            io_wr_stb     <= 1'b0;
            io_wdata      <= 8'h00;
            busy          <= 1'b0;
            grant_host    <= 1'b0;
        end else begin
            cpu_ack   <= 1'b0;
            host_ack  <= 1'b0;
            io_wr_stb <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cpu_req || host_req) begin
                        state_reg     <= ADDR;
                        grant_host    <= pick_host;
                        last_host_reg <= pick_host;
                        addr_reg      <= sel_addr;
                        we_reg        <= pick_host ? host_we : cpu_we;
                        wdata_reg     <= pick_host ? host_wdata : cpu_wdata;
                        bus_out       <= sel_addr;
                        bus_oe        <= 8'hFF;
                        mem_le        <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                ADDR: begin
                    state_reg <= LATCH;
                    mem_le    <= 1'b0;
                end
                LATCH: begin
                    if (we_reg) begin
                        state_reg <= DATA;
                        bus_out   <= wdata_reg;
                    end else begin
                        state_reg <= TURN;
                        bus_oe    <= 8'h00;
                        mem_oe_n  <= 1'b0;
                    end
                end
                TURN: begin
                    state_reg <= SAMPLE;
                    wait_reg  <= 3'd0;
                end
                SAMPLE: begin
                    if (wait_reg == WAIT_LAST) begin
                        state_reg <= DONE;
                        mem_oe_n  <= 1'b1;
                        if (grant_host) begin
                            host_ack   <= 1'b1;
                            host_rdata <= bus_in;
                        end else begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= bus_in;
                        end
                    end else begin
                        wait_reg <= wait_reg + 3'd1;
                    end
                end
                DATA: begin
                    state_reg <= STROBE;
                    wait_reg  <= 3'd0;
                    // The I/O register write never reaches the SRAM.
                    mem_we_n  <= protected_wr;
                end
                STROBE: begin
                    if (wait_reg == WAIT_LAST) begin
                        state_reg <= DONE;
                        mem_we_n  <= 1'b1;
                        host_ack  <= grant_host;
                        cpu_ack   <= !grant_host;
                        if (protected_wr) begin
                            io_wr_stb <= 1'b1;
                            io_wdata  <= wdata_reg;
                        end
                    end else begin
                        wait_reg <= wait_reg + 3'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    mem_le    <= 1'b1;
                    bus_oe    <= 8'h00;
                    bus_out   <= 8'h00;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: three instances (defaults, WAIT_CYCLES=2, PRIO_MODE=1),
// each attached to a behavioural latched-address SRAM.
module tb_sram_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n      [3];
    logic       cpu_req    [3];
    logic       cpu_we     [3];
    logic [7:0] cpu_addr   [3];
    logic [7:0] cpu_wdata  [3];
    logic       cpu_ack    [3];
    logic [7:0] cpu_rdata  [3];
    logic       host_req   [3];
    logic       host_we    [3];
    logic [7:0] host_addr  [3];
    logic [7:0] host_wdata [3];
    logic       host_ack   [3];
    logic [7:0] host_rdata [3];
    logic       mem_le     [3];
    logic       mem_oe_n   [3];
    logic       mem_we_n   [3];
    logic [7:0] bus_out    [3];
    logic [7:0] bus_oe     [3];
    logic [7:0] bus_in     [3];
    logic       io_wr_stb  [3];
    logic [7:0] io_wdata   [3];
    logic       busy       [3];
    logic       grant_host [3];
    logic       init_req;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [3][256];

    function automatic logic [7:0] init_val(input logic [7:0] a);
        if (a == 8'h12) return 8'h5A;
        if (a == 8'hFF) return 8'hC3;
        return 8'(a * 7 + 3);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        logic [7:0] sram [256];
        logic [7:0] lat_addr;
        int         inv_err = 0;

        sram_bus_arbiter #(
            .WAIT_CYCLES (gi == 1 ? 2 : 0),
            .PRIO_MODE   (gi == 2 ? 1 : 0),
            .PROTECT_ADDR(8'hFF)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[gi]),
            .cpu_req   (cpu_req[gi]),
            .cpu_we    (cpu_we[gi]),
            .cpu_addr  (cpu_addr[gi]),
            .cpu_wdata (cpu_wdata[gi]),
            .cpu_ack   (cpu_ack[gi]),
            .cpu_rdata (cpu_rdata[gi]),
            .host_req  (host_req[gi]),
            .host_we   (host_we[gi]),
            .host_addr (host_addr[gi]),
            .host_wdata(host_wdata[gi]),
            .host_ack  (host_ack[gi]),
            .host_rdata(host_rdata[gi]),
            .mem_le    (mem_le[gi]),
            .mem_oe_n  (mem_oe_n[gi]),
            .mem_we_n  (mem_we_n[gi]),
            .bus_out   (bus_out[gi]),
            .bus_oe    (bus_oe[gi]),
            .bus_in    (bus_in[gi]),
            .io_wr_stb (io_wr_stb[gi]),
            .io_wdata  (io_wdata[gi]),
            .busy      (busy[gi]),
            .grant_host(grant_host[gi])
        );

        assign bus_in[gi] = (mem_oe_n[gi] === 1'b0) ? sram[lat_addr] : 8'hA5;

        always @(posedge clk) begin
            if (init_req) begin
                for (int a = 0; a < 256; a++) sram[a] <= init_val(8'(a));
                lat_addr <= 8'h00;
            end else begin
                if (mem_le[gi] === 1'b1) lat_addr <= bus_out[gi];
                if (mem_we_n[gi] === 1'b0) sram[lat_addr] <= bus_out[gi];
            end
        end

        // Bus-safety rules that must hold on every cycle.
        always @(negedge clk) begin
            if (rst_n[gi] === 1'b1 && !init_req) begin
                if ((mem_oe_n[gi] === 1'b0 && mem_we_n[gi] === 1'b0) ||
                    (mem_oe_n[gi] === 1'b0 && bus_oe[gi] !== 8'h00) ||
                    (mem_we_n[gi] === 1'b0 && bus_oe[gi] !== 8'hFF)) begin
                    inv_err++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int i);
        rst_n[i] = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state",
              {mem_le[i], mem_oe_n[i], mem_we_n[i], bus_oe[i], bus_out[i], cpu_ack[i], host_ack[i],
               cpu_rdata[i], host_rdata[i], io_wr_stb[i], io_wdata[i], busy[i], grant_host[i]},
              {1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        rst_n[i] = 1'b1;
    endtask

    task automatic run_txn(input int i, input bit h, input bit we, input logic [7:0] a,
                           input logic [7:0] d, output logic [7:0] rd, output int lat,
                           output logic [63:0] oe_m, output logic [63:0] we_m,
                           output int stb, output logic [7:0] iod);
        @(negedge clk);
        if (h) begin
            host_req[i] = 1'b1; host_we[i] = we; host_addr[i] = a; host_wdata[i] = d;
        end else begin
            cpu_req[i] = 1'b1; cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = d;
        end
        lat = 0; oe_m = '0; we_m = '0; stb = 0; iod = 8'h00; rd = 8'h00;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_oe_n[i] === 1'b0) oe_m[k] = 1'b1;
            if (mem_we_n[i] === 1'b0) we_m[k] = 1'b1;
            if (io_wr_stb[i] === 1'b1) begin
                stb++;
                iod = io_wdata[i];
            end
            if (k == 1) begin
                check("addr_phase", {bus_oe[i], bus_out[i], 7'b0, mem_le[i], 7'b0, busy[i]},
                      {8'hFF, a, 8'h01, 8'h01});
                // The arbiter must have captured the request; disturb the live inputs.
                if (h) begin
                    host_we[i] = ~we; host_addr[i] = ~a; host_wdata[i] = ~d;
                end else begin
                    cpu_we[i] = ~we; cpu_addr[i] = ~a; cpu_wdata[i] = ~d;
                end
            end
            if ((h && host_ack[i] === 1'b1) || (!h && cpu_ack[i] === 1'b1)) begin
                lat = k;
                rd  = h ? host_rdata[i] : cpu_rdata[i];
            end
        end
        if (h) host_req[i] = 1'b0;
        else   cpu_req[i]  = 1'b0;
    endtask

    task automatic apply(input int i, input bit h, input bit we, input logic [7:0] a,
                         input logic [7:0] d, input int exp_lat, input logic [63:0] exp_mask,
                         input logic [7:0] exp_rd, input int exp_stb, input logic [7:0] exp_io);
        logic [7:0]  rd, iod;
        logic [63:0] oe_m, we_m;
        int          lat, stb;
        run_txn(i, h, we, a, d, rd, lat, oe_m, we_m, stb, iod);
        check("latency", 64'(lat), 64'(exp_lat));
        check(we ? "we_n_window" : "oe_n_window", we ? we_m : oe_m, exp_mask);
        check(we ? "oe_n_on_write" : "we_n_on_read", we ? oe_m : we_m, 64'h0);
        if (!we) check("rdata", 64'(rd), 64'(exp_rd));
        check("io_stb_count", 64'(stb), 64'(exp_stb));
        if (exp_stb != 0) check("io_wdata", 64'(iod), 64'(exp_io));
        check("grant_host", 64'(grant_host[i]), 64'(h));
        $display("txn inst=%0d %s %s addr=%02h wdata=%02h lat=%0d rdata=%02h stb=%0d",
                 i, h ? "host" : "cpu ", we ? "wr" : "rd", a, d, lat, rd, stb);
    endtask

    typedef struct {
        int          inst;
        bit          h;
        bit          we;
        logic [7:0]  a;
        logic [7:0]  d;
        int          lat;
        logic [63:0] mask;
        logic [7:0]  rd;
        int          stb;
        logic [7:0]  io;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{0, 1'b0, 1'b0, 8'h12, 8'h00, 5, 64'h18, 8'h5A, 0, 8'h00};
        tbl[1] = '{0, 1'b1, 1'b1, 8'h80, 8'h34, 5, 64'h10, 8'h00, 0, 8'h00};
        tbl[2] = '{0, 1'b1, 1'b0, 8'h80, 8'h00, 5, 64'h18, 8'h34, 0, 8'h00};
        tbl[3] = '{0, 1'b0, 1'b1, 8'hFF, 8'h07, 5, 64'h00, 8'h00, 1, 8'h07};
        tbl[4] = '{0, 1'b0, 1'b0, 8'hFF, 8'h00, 5, 64'h18, 8'hC3, 0, 8'h00};
        tbl[5] = '{1, 1'b0, 1'b0, 8'h12, 8'h00, 7, 64'h78, 8'h5A, 0, 8'h00};
        tbl[6] = '{1, 1'b1, 1'b1, 8'h40, 8'h99, 7, 64'h70, 8'h00, 0, 8'h00};
        tbl[7] = '{1, 1'b0, 1'b0, 8'h40, 8'h00, 7, 64'h78, 8'h99, 0, 8'h00};
        tbl[8] = '{1, 1'b1, 1'b1, 8'hFF, 8'h5E, 7, 64'h00, 8'h00, 1, 8'h5E};

        init_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = 8'h00; cpu_wdata[i] = 8'h00;
            host_req[i] = 1'b0; host_we[i] = 1'b0; host_addr[i] = 8'h00; host_wdata[i] = 8'h00;
            for (int a = 0; a < 256; a++) ref_mem[i][a] = init_val(8'(a));
        end
        repeat (2) @(negedge clk);
        init_req = 1'b0;
        for (int i = 0; i < 3; i++) do_reset(i);

        for (int v = 0; v < 9; v++) begin
            apply(tbl[v].inst, tbl[v].h, tbl[v].we, tbl[v].a, tbl[v].d,
                  tbl[v].lat, tbl[v].mask, tbl[v].rd, tbl[v].stb, tbl[v].io);
            if (tbl[v].we && tbl[v].a != 8'hFF) ref_mem[tbl[v].inst][tbl[v].a] = tbl[v].d;
        end
        check("io_wdata_held", 64'(io_wdata[0]), 64'h07);

        // Random traffic against a transaction-level memory model.
        for (int r = 0; r < 80; r++) begin
            int          i, w;
            bit          h, we, prot;
            logic [7:0]  a, d, exp_rd;
            logic [63:0] mask;
            i    = int'($urandom_range(0, 1));
            w    = (i == 1) ? 2 : 0;
            h    = 1'($urandom);
            we   = 1'($urandom);
            a    = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
            d    = 8'($urandom);
            prot = we && (a == 8'hFF);
            exp_rd = ref_mem[i][a];
            if (!we)       mask = ((64'd1 << (w + 2)) - 64'd1) << 3;
            else if (prot) mask = 64'h0;
            else           mask = ((64'd1 << (w + 1)) - 64'd1) << 4;
            apply(i, h, we, a, d, 5 + w, mask, exp_rd, prot ? 1 : 0, d);
            if (we && !prot) ref_mem[i][a] = d;
        end

        // Reset in the middle of a write strobe.
        begin
            bit found;
            found = 1'b0;
            @(negedge clk);
            cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 8'h30; cpu_wdata[0] = 8'h55;
            for (int k = 0; k < 20 && !found; k++) begin
                @(negedge clk);
                if (mem_we_n[0] === 1'b0) found = 1'b1;
            end
            check("strobe_reached", 64'(found), 64'h1);
            rst_n[0] = 1'b0;
            @(negedge clk);
            cpu_req[0] = 1'b0;
            check("rst_mid_strobe",
                  {mem_we_n[0], mem_oe_n[0], mem_le[0], bus_oe[0], busy[0], cpu_ack[0], host_ack[0]},
                  {1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
            rst_n[0] = 1'b1;
            @(negedge clk);
            check("after_rst_quiet", {mem_we_n[0], busy[0], cpu_ack[0]}, {1'b1, 1'b0, 1'b0});
            apply(0, 1'b0, 1'b0, 8'h12, 8'h00, 5, 64'h18, ref_mem[0][8'h12], 0, 8'h00);
        end

        // Both ports requesting continuously: round-robin vs fixed priority.
        for (int p = 0; p < 2; p++) begin
            int i, n, cpu_acks;
            bit got [4];
            i = (p == 0) ? 0 : 2;
            do_reset(i);
            n = 0; cpu_acks = 0;
            @(negedge clk);
            host_we[i] = 1'b0; host_addr[i] = 8'h10; host_req[i] = 1'b1;
            cpu_we[i]  = 1'b0; cpu_addr[i]  = 8'h20; cpu_req[i]  = 1'b1;
            for (int k = 0; k < 100 && n < 4; k++) begin
                @(negedge clk);
                if (cpu_ack[i] === 1'b1) cpu_acks++;
                if (host_ack[i] === 1'b1 && n < 4) begin got[n] = 1'b1; n++; end
                else if (cpu_ack[i] === 1'b1 && n < 4) begin got[n] = 1'b0; n++; end
            end
            host_req[i] = 1'b0; cpu_req[i] = 1'b0;
            check("arb_count", 64'(n), 64'd4);
            for (int j = 0; j < 4; j++) begin
                bit exp_h;
                exp_h = (p == 1) ? 1'b1 : (j % 2 == 0);
                check("arb_grant", 64'(got[j]), 64'(exp_h));
                $display("arb inst=%0d grant%0d=%s", i, j, got[j] ? "host" : "cpu");
            end
            if (p == 1) check("prio_no_cpu_ack", 64'(cpu_acks), 64'd0);
            repeat (8) @(negedge clk);
        end

        check("bus_rules_0", 64'(g_dut[0].inv_err), 64'd0);
        check("bus_rules_1", 64'(g_dut[1].inv_err), 64'd0);
        check("bus_rules_2", 64'(g_dut[2].inv_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
Owns the shared 8-bit multiplexed external SRAM bus, which carries the address latch (LE), active-low OE and active-low WE. It arbitrates between the subneg core port (cpu_*) and a host loader/debug port (host_*), and runs one complete latched-address read or write cycle per grant. Writes to the protected I/O address are never sent to the SRAM; they become an io_wr_stb strobe instead.

Parameters:
WAIT_CYCLES, 0, extra cycles added to the SAMPLE (read) or STROBE (write) state, range 0-7.
PRIO_MODE, 0, 0 = round-robin; 1 = host has fixed priority over cpu.
PROTECT_ADDR, 8'hFF, write address that is redirected to io_wr_stb.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
cpu_req  in  1  level request, held high until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  8  address
cpu_wdata  in  8  write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  read data, valid while cpu_ack=1 and held until the next cpu read
host_req, host_we, host_addr, host_wdata, host_ack, host_rdata  same widths and rules as the cpu_* set
mem_le  out  1  address latch enable (1 = transparent)
mem_oe_n  out  1  SRAM output enable, active-low
mem_we_n  out  1  SRAM write enable, active-low
bus_out  out  8  shared bus drive value
bus_oe  out  8  per-bit drive enable (8'hFF = drive, 8'h00 = input)
bus_in  in  8  shared bus sampled value
io_wr_stb  out  1  one-cycle pulse for a protected write
io_wdata  out  8  data for the protected write, held after the pulse
busy  out  1  high in every state except IDLE
grant_host  out  1  owner of the current or most recent transaction (1 = host)

Behaviour:
- Reset (rst_n=0 at a clk edge, including in the middle of a transaction): state=IDLE, mem_le=1, mem_oe_n=1, mem_we_n=1, bus_oe=8'h00, bus_out=0, both acks=0, both rdata=0, io_wr_stb=0, io_wdata=0, busy=0, grant_host=0. The round-robin pointer is cleared so that host wins the first tie. A partial write must never produce a we_n low pulse after reset.
- All outputs are registered.
- IDLE: if any req is high, the arbiter picks a winner and captures its addr, we and wdata into internal registers. Later changes on the requester's inputs are ignored until ack.
  - PRIO_MODE=0: when both request, the port not served last wins.
  - PRIO_MODE=1: host always wins.
- Read sequence, one state per cycle:
  - ADDR: bus_oe=FF, bus_out=addr, mem_le=1, mem_oe_n=1, mem_we_n=1.
  - LATCH: mem_le=0.
  - TURN: bus_oe=00, mem_oe_n=0.
  - SAMPLE: lasts 1+WAIT_CYCLES cycles; bus_in is captured on the last cycle.
  - DONE: ack=1, rdata valid, mem_oe_n=1.
- Write sequence:
  - ADDR: same as the read ADDR state.
  - LATCH: mem_le=0.
  - DATA: bus_out=wdata, bus_oe=FF.
  - STROBE: lasts 1+WAIT_CYCLES cycles; mem_we_n=0.
  - DONE: mem_we_n=1, data still driven, ack=1.
- Latency: req first seen high in IDLE in cycle N gives ADDR in cycle N+1 and ack in cycle N+5+WAIT_CYCLES.
- mem_oe_n and mem_we_n are never low in the same cycle. bus_oe is 00 whenever mem_oe_n=0.
- DONE always returns to IDLE. Back-to-back transactions therefore cost one IDLE cycle each. The requester drops req at the edge where it sees ack=1; a req still high in IDLE starts a new transaction.
- Protected write (we=1, addr==PROTECT_ADDR, either port): the full write sequence runs but mem_we_n stays 1. In DONE, io_wr_stb=1 and io_wdata=wdata. Reads of PROTECT_ADDR are ordinary SRAM reads.
- After DONE, mem_le returns to 1 and bus_oe to 00 in IDLE.

Test Plan:
- cpu read addr 0x12, SRAM model returns 0x5A -> ADDR in cycle N+1 with bus_out=0x12, le falls at N+2, oe_n low N+3..N+4, cpu_ack at N+5 with cpu_rdata=0x5A.
- host write 0x34 to 0x80 -> we_n low for exactly 1 cycle (N+4) while bus_out=0x34 and bus_oe=FF; host_ack at N+5; SRAM model holds 0x34 at 0x80.
- PRIO_MODE=0, both ports requesting continuously for 4 transactions -> grant order host, cpu, host, cpu. PRIO_MODE=1, same stimulus -> 4 host grants, cpu_ack never asserted.
- cpu write 0x07 to 0xFF -> mem_we_n stays 1 throughout; io_wr_stb one pulse coinciding with cpu_ack; io_wdata=0x07.
- WAIT_CYCLES=2 read -> SAMPLE lasts 3 cycles, ack at N+7. WAIT_CYCLES=2 write -> we_n low for 3 cycles.
- rst_n low during STROBE -> next cycle we_n=1, bus_oe=00, state IDLE, no ack; a new cpu read afterwards completes normally.
